// File: rtl/ddr3_fb_arbiter.sv
// rtl/ddr3_fb_arbiter.sv - burst scheduler sharing one DDR3 port between two camera writers and the display reader
// Ping-pong frame addressing per camera; the display reads the selected camera's last completed bank.
module ddr3_fb_arbiter #(
    parameter int ADDR_W     = 28,
    parameter int LEN_W      = 7,
    parameter int BURST_LEN  = 64,
    parameter int BURST_INC  = 512,
    parameter int FRAME_SPAN = 393216,
    parameter logic [ADDR_W-1:0] CH0_BASE = 28'h0000000,
    parameter logic [ADDR_W-1:0] CH1_BASE = 28'h0400000,
    parameter logic [ADDR_W-1:0] BANK_OFS = 28'h0200000,
    parameter bit PINGPONG = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              calib_done,
    input  logic              wr0_load,
    input  logic              wr0_req,
    input  logic              wr1_load,
    input  logic              wr1_req,
    input  logic              rd_load,
    input  logic              rd_req,
    input  logic              rd_urgent,
    input  logic              rd_sel,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_wr,
    output logic [1:0]        cmd_ch,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [LEN_W-1:0]  cmd_len,
    input  logic              burst_done,
    output logic [2:0]        gnt,
    output logic [1:0]        wr_bank,
    output logic [1:0]        frame_done
);
    localparam logic [ADDR_W-1:0] INC  = BURST_INC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] SPAN = FRAME_SPAN[ADDR_W-1:0];

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;
    state_t state, state_nx;

    logic [1:0]        rr_last, win;
    logic              win_ok;
    logic [2:0]        req, ld, held, pend;
    logic              pend_sel, rd_cam, rd_bank, sel_now;
    logic [1:0]        last_done_bank;
    logic [ADDR_W-1:0] wptr [2];
    logic [ADDR_W-1:0] rptr, nxt_r, addr0, addr1, addr_r;
    logic [ADDR_W-1:0] nxt_w [2];
    logic              done_now;

    assign req      = {rd_req, wr1_req, wr0_req};
    assign ld       = {rd_load, wr1_load, wr0_load};
    assign done_now = (state == BUSY) && burst_done;
    assign sel_now  = rd_load ? rd_sel : pend_sel;
    assign nxt_w[0] = wptr[0] + INC;
    assign nxt_w[1] = wptr[1] + INC;
    assign nxt_r    = rptr + INC;

    assign addr0  = CH0_BASE + ((PINGPONG && wr_bank[0]) ? BANK_OFS : '0) + wptr[0];
    assign addr1  = CH1_BASE + ((PINGPONG && wr_bank[1]) ? BANK_OFS : '0) + wptr[1];
    assign addr_r = (rd_cam ? CH1_BASE : CH0_BASE) + ((PINGPONG && rd_bank) ? BANK_OFS : '0) + rptr;

    // Urgent read preempts; otherwise round-robin starting after the last winner.
    always_comb begin
        logic [1:0] c;
        win    = 2'd0;
        win_ok = 1'b0;
        c      = (rr_last == 2'd2) ? 2'd0 : rr_last + 2'd1;
        if (calib_done) begin
            if (rd_req && rd_urgent) begin
                win    = 2'd2;
                win_ok = 1'b1;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    if (!win_ok && req[c]) begin
                        win    = c;
                        win_ok = 1'b1;
                    end
                    c = (c == 2'd2) ? 2'd0 : c + 2'd1;
                end
            end
        end
    end

    // A channel winning this cycle counts as granted so its load is deferred, not lost.
    always_comb begin
        for (int n = 0; n < 3; n++) begin
            held[n] = ((state != IDLE) && (cmd_ch == 2'(n))) ||
                      ((state == IDLE) && win_ok && (win == 2'(n)));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (win_ok)     state_nx = ISSUE;
            ISSUE:   if (cmd_ready)  state_nx = BUSY;
            BUSY:    if (burst_done) state_nx = IDLE;
            default:                 state_nx = IDLE;
        endcase
    end

    always_comb begin
        cmd_valid = (state == ISSUE);
        gnt       = (state != IDLE) ? (3'b001 << cmd_ch) : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_wr         <= 1'b0;
            cmd_ch         <= 2'd0;
            cmd_addr       <= '0;
            cmd_len        <= '0;
            rr_last        <= 2'd2;
            wptr[0]        <= '0;
            wptr[1]        <= '0;
            rptr           <= '0;
            wr_bank        <= 2'b00;
            last_done_bank <= 2'b00;
            rd_cam         <= 1'b0;
            rd_bank        <= 1'b0;
            pend           <= 3'b000;
            pend_sel       <= 1'b0;
            frame_done     <= 2'b00;
        end else begin
            frame_done <= 2'b00;
            if (state == IDLE && win_ok) begin
                cmd_ch   <= win;
                rr_last  <= win;
                cmd_wr   <= (win != 2'd2);
                cmd_len  <= BURST_LEN[LEN_W-1:0];
                cmd_addr <= (win == 2'd0) ? addr0 : (win == 2'd1) ? addr1 : addr_r;
            end
            for (int n = 0; n < 2; n++) begin
                if (ld[n] && !held[n]) wptr[n] <= '0;
                if (ld[n] &&  held[n]) pend[n] <= 1'b1;
            end
            if (rd_load && !held[2]) begin
                rptr    <= '0;
                rd_cam  <= rd_sel;
                rd_bank <= last_done_bank[rd_sel];
            end
            if (rd_load && held[2]) begin
                pend[2]  <= 1'b1;
                pend_sel <= rd_sel;
            end
            if (done_now) begin
                pend[cmd_ch] <= 1'b0;
                if (cmd_ch == 2'd2) begin
                    if (pend[2] || rd_load) begin
                        rptr    <= '0;
                        rd_cam  <= sel_now;
                        rd_bank <= last_done_bank[sel_now];
                    end else begin
                        rptr <= (nxt_r >= SPAN) ? '0 : nxt_r;
                    end
                end else begin
                    for (int n = 0; n < 2; n++) begin
                        if (cmd_ch == 2'(n)) begin
                            // A wrap wins over a coincident load: the frame is complete.
                            if (nxt_w[n] >= SPAN) begin
                                wptr[n]           <= '0;
                                last_done_bank[n] <= wr_bank[n];
                                if (PINGPONG) wr_bank[n] <= ~wr_bank[n];
                                frame_done[n]     <= 1'b1;
                            end else if (pend[n] || ld[n]) begin
                                wptr[n] <= '0;
                            end else begin
                                wptr[n] <= nxt_w[n];
                            end
                        end
                    end
                end
            end
        end
    end
endmodule

// File: doc/ddr3_fb_arbiter.md
Name: ddr3_fb_arbiter

Overview:
- Burst-level scheduler in front of the DDR3 frame-buffer controller for the dual-camera build.
- Shares one DDR3 burst port between three requesters: camera-0 write, camera-1 write, and HDMI read.
- Generates ping-pong frame addresses per camera and selects which camera's last completed frame the display reads.
- Sits between the per-channel FIFOs (which raise burst requests) and the MIG-side burst engine (which executes one command and reports completion).

Parameters:
- ADDR_W, 28, width of the DDR3 app address.
- LEN_W, 7, width of the burst length field.
- BURST_LEN, 64, 128-bit words per burst, driven on cmd_len.
- BURST_INC, 512, address advance per completed burst (BURST_LEN*8).
- FRAME_SPAN, 393216, address units per frame (1024*768 pixels x 16 bit / 2-byte units, halved per MIG addressing).
- CH0_BASE, 28'h0000000, camera-0 frame region base.
- CH1_BASE, 28'h0400000, camera-1 frame region base.
- BANK_OFS, 28'h0200000, offset of ping-pong bank 1.
- PINGPONG, 1, 1 = two banks per camera, 0 = single bank.

Ports:
- clk, in, 1, DDR3 user clock (ui_clk).
- rst, in, 1, synchronous active-high reset.
- calib_done, in, 1, DDR3 calibration complete. No grants while low.
- wr0_load, in, 1, camera-0 frame-start pulse (one clk).
- wr0_req, in, 1, camera-0 write FIFO holds >= BURST_LEN words.
- wr1_load, in, 1, camera-1 frame-start pulse.
- wr1_req, in, 1, camera-1 write FIFO holds >= BURST_LEN words.
- rd_load, in, 1, display frame-start pulse.
- rd_req, in, 1, read FIFO has room for BURST_LEN words.
- rd_urgent, in, 1, read FIFO below low watermark.
- rd_sel, in, 1, camera shown on the next display frame. Sampled on rd_load.
- cmd_valid, out, 1, burst command valid.
- cmd_ready, in, 1, burst engine accepts the command.
- cmd_wr, out, 1, 1 = write, 0 = read.
- cmd_ch, out, 2, 0 = wr0, 1 = wr1, 2 = rd.
- cmd_addr, out, ADDR_W, burst start address.
- cmd_len, out, LEN_W, burst length (= BURST_LEN).
- burst_done, in, 1, pulse marking the last beat of the current burst.
- gnt, out, 3, one-hot grant {rd, wr1, wr0}, used by FIFOs to pop/push.
- wr_bank, out, 2, current write bank of {cam1, cam0}.
- frame_done, out, 2, one-clk pulse per camera when its frame write completes.

Behaviour:
- Reset (rst high at a clk edge) sets:
  - state to IDLE; all outputs to 0.
  - ptrs and banks to 0; last_done_bank to 0; rd_cam to 0.
  - rr_last to rd, so wr0 has first priority.
  - pending-load flags cleared.
- Reset mid-burst drops the grant immediately. The burst engine is reset from the same rst.
- FSM IDLE:
  - Arbitrates only if calib_done.
  - Candidates are wr0_req, wr1_req, rd_req.
  - rd_req & rd_urgent wins outright.
  - Otherwise round-robin in order wr0 -> wr1 -> rd, starting after rr_last.
  - On a winner: latch ch, cmd_wr, cmd_addr; set gnt; update rr_last; go to ISSUE. cmd_valid rises the cycle after the req is sampled.
- Address formation:
  - write chN: CHn_BASE + (PINGPONG & wr_bank[n] ? BANK_OFS : 0) + wptr[n].
  - read: base of rd_cam + (PINGPONG & rd_bank ? BANK_OFS : 0) + rptr.
- FSM ISSUE: hold cmd_valid and all cmd_* stable until cmd_valid & cmd_ready. Then drop cmd_valid and go to BUSY.
- FSM BUSY:
  - gnt held until burst_done, then go to IDLE (1 idle cycle between bursts).
  - Pointer update on burst_done:
    - ptr += BURST_INC.
    - If the new value >= FRAME_SPAN, ptr <= 0.
    - For a write wrap: last_done_bank[n] <= wr_bank[n]; wr_bank[n] toggles if PINGPONG; frame_done[n] pulses.
    - A read wrap only sets ptr to 0.
  - burst_done outside BUSY is ignored.
- wrN_load:
  - Channel not granted: wptr[n] <= 0 next cycle; bank unchanged (partial frame discarded).
  - Channel granted: set pending; at burst_done apply ptr <= 0 instead of the increment, with no bank toggle and no frame_done.
- rd_load:
  - Effect: rptr <= 0, rd_cam <= rd_sel, rd_bank <= last_done_bank[rd_sel].
  - Channel not granted: takes effect next cycle.
  - Read granted: deferred to burst_done, same as a write load.
- Simultaneous wrap and load on the same channel: the wrap completes (toggle + frame_done); the load is then redundant.
- calib_done falling in ISSUE/BUSY: the current burst completes; no new grants.
- All arithmetic is unsigned ADDR_W bits. FRAME_SPAN must be a multiple of BURST_INC.

Test Plan:
1. Reset, calib_done=1, wr0_req=wr1_req=rd_req=1 constant, cmd_ready=1, burst_done 4 clk after accept.
   - Grant order: wr0, wr1, rd, wr0, …
   - cmd_addr for wr0: 0 then 0x200; for wr1: 0x400000 then 0x400200.
2. rd_urgent=1 with all reqs high → next grant is rd regardless of rr_last.
3. wr0 alone, 768 bursts:
   - Last cmd_addr 0x05FE00.
   - frame_done[0] pulses; wr_bank[0]=1.
   - Next cmd_addr 0x200000.
4. Complete one cam1 frame, then rd_load with rd_sel=1 → read cmd_addr 0x400000 (bank 0). After a second cam1 frame and a new rd_load, read cmd_addr is 0x600000.
5. wr0_load asserted during a wr0 BUSY at wptr=0x1000 → next wr0 cmd_addr is base + 0; no frame_done.
6. cmd_ready held low 10 clk → cmd_valid and cmd_addr stable; rst asserted mid-BUSY → gnt=0 and cmd_valid=0 the next clk, and the next grant after release goes to wr0.
